// File: rtl/downsampler_2x2_pkg.sv
// Shared defaults for the 2x2 decimation stage of the sampling pyramid.
// OUT_W/OUT_H are also used by the downstream upsampler stage.
package downsampler_2x2_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IN_W   = 800;
    localparam int DEF_IN_H   = 600;
    localparam int DEF_CNT_W  = 10;
    localparam int DEF_OUT_W  = DEF_IN_W / 2;
    localparam int DEF_OUT_H  = DEF_IN_H / 2;

endpackage

// File: rtl/downsampler_2x2_if.sv
// Pixel-stream interface: raster input (valid/din) and decimated output with coordinates.
interface downsampler_2x2_if
    import downsampler_2x2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              valid;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dataout;
    logic              validout;
    logic [CNT_W-1:0]  rownum;
    logic [CNT_W-1:0]  colnum;

    modport master (
        output valid, din,
        input  dataout, validout, rownum, colnum
    );

    modport slave (
        input  valid, din,
        output dataout, validout, rownum, colnum
    );

endinterface

// File: rtl/downsampler_linebuf.sv
// Simple dual-port line buffer holding horizontal pair sums of the previous even row.
// Synchronous write, registered read; read data holds until the next read.
module downsampler_linebuf #(
    parameter int DEPTH = 400,
    parameter int WIDTH = 9,
    parameter int AW    = 9
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; every entry is written on an even row before it is read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/downsampler_2x2.sv
// Decimates a raster stream by 2 in each axis; each output is the rounded mean of a 2x2 block.
// Even rows store horizontal pair sums in the line buffer; odd rows combine and emit.
module downsampler_2x2
    import downsampler_2x2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IN_W   = DEF_IN_W,
    parameter int IN_H   = DEF_IN_H,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic               clock,
    input logic               reset_n,
    downsampler_2x2_if.slave  px
);

    localparam int OUT_W = IN_W / 2;
    localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [CNT_W-1:0]  in_col_q, in_col_d;
    logic [CNT_W-1:0]  in_row_q, in_row_d;
    logic [DATA_W:0]   hsum_q, hsum_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              validout_q, validout_d;
    logic [CNT_W-1:0]  rownum_q, rownum_d;
    logic [CNT_W-1:0]  colnum_q, colnum_d;

    logic [DATA_W:0]   pair;
    logic [DATA_W:0]   lb_rdata;
    logic [DATA_W+1:0] total;
    logic [AW-1:0]     k;
    logic              col_odd, row_odd, lb_we, lb_re;

    assign col_odd = in_col_q[0];
    assign row_odd = in_row_q[0];
    assign k       = in_col_q[AW:1];
    assign pair    = hsum_q + {1'b0, px.din};
    assign total   = {1'b0, pair} + {1'b0, lb_rdata};

    // The odd-row read is issued on the even beat so the data is ready by the odd beat.
    assign lb_we = px.valid & col_odd & ~row_odd;
    assign lb_re = px.valid & ~col_odd & row_odd;

    downsampler_linebuf #(
        .DEPTH (OUT_W),
        .WIDTH (DATA_W + 1),
        .AW    (AW)
    ) u_linebuf (
        .clock (clock),
        .we    (lb_we),
        .waddr (k),
        .wdata (pair),
        .re    (lb_re),
        .raddr (k),
        .rdata (lb_rdata)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        in_col_d   = in_col_q;
        in_row_d   = in_row_q;
        hsum_d     = hsum_q;
        validout_d = 1'b0;
        dataout_d  = dataout_q;
        rownum_d   = rownum_q;
        colnum_d   = colnum_q;
        if (px.valid) begin
            if (!col_odd) begin
                hsum_d = {1'b0, px.din};
            end else if (row_odd) begin
                validout_d = 1'b1;
                dataout_d  = DATA_W'((total + (DATA_W + 2)'(2)) >> 2);
                rownum_d   = in_row_q >> 1;
                colnum_d   = in_col_q >> 1;
            end
            // Output coordinates above are taken from the pre-wrap counters.
            if (in_col_q == CNT_W'(IN_W - 1)) begin
                in_col_d = '0;
                in_row_d = (in_row_q == CNT_W'(IN_H - 1)) ? '0 : in_row_q + CNT_W'(1);
            end else begin
                in_col_d = in_col_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_col_q   <= '0;
            in_row_q   <= '0;
            hsum_q     <= '0;
            dataout_q  <= '0;
            validout_q <= 1'b0;
            rownum_q   <= '0;
            colnum_q   <= '0;
        end else begin
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            hsum_q     <= hsum_d;
            dataout_q  <= dataout_d;
            validout_q <= validout_d;
            rownum_q   <= rownum_d;
            colnum_q   <= colnum_d;
        end
    end

    assign px.dataout  = dataout_q;
    assign px.validout = validout_q;
    assign px.rownum   = rownum_q;
    assign px.colnum   = colnum_q;

endmodule

// File: tb/tb_downsampler_2x2.sv
// Scoreboard bench for downsampler_2x2 on a reduced 16x8 raster.
// Expected block means are computed from the driven image and queued as the closing pixel is sent.
module tb_downsampler_2x2;

    localparam int DW   = 8;
    localparam int IW   = 16;
    localparam int IH   = 8;
    localparam int CW   = 10;
    localparam int OW   = IW / 2;
    localparam int OH   = IH / 2;
    localparam int NOUT = OW * OH;

    typedef enum int {K_CONST, K_RAMP, K_RAND, K_BLOCKS} kind_e;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    downsampler_2x2_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    downsampler_2x2 #(
        .DATA_W (DW),
        .IN_W   (IW),
        .IN_H   (IH),
        .CNT_W  (CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .px      (bus)
    );

    always #5 clock = ~clock;

    int            checks   = 0;
    int            failures = 0;
    int            pulses   = 0;
    exp_t          sb_q[$];
    logic [2*CW-1:0] log_rc[$];
    logic [DW-1:0] img [IH][IW];
    logic [DW-1:0] got [OH][OW];
    logic [CW-1:0] last_row = '0;
    logic [CW-1:0] last_col = '0;

    // Output monitor: pops the scoreboard on every pulse, and watches for pulses during reset.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            checks++;
            if (bus.validout !== 1'b0) begin
                failures++;
                $display("FAIL validout_in_reset got=%b want=0", bus.validout);
            end
        end else if (bus.validout === 1'b1) begin
            pulses++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL extra_pulse got data=%0d row=%0d col=%0d want no pulse",
                         bus.dataout, bus.rownum, bus.colnum);
            end else begin
                e = sb_q.pop_front();
                if (bus.dataout !== e.data || bus.rownum !== e.row || bus.colnum !== e.col) begin
                    failures++;
                    $display("FAIL pixel got data=%0d row=%0d col=%0d want data=%0d row=%0d col=%0d",
                             bus.dataout, bus.rownum, bus.colnum, e.data, e.row, e.col);
                end
            end
            if (bus.rownum < CW'(OH) && bus.colnum < CW'(OW)) begin
                got[bus.rownum][bus.colnum] = bus.dataout;
            end
            last_row = bus.rownum;
            last_col = bus.colnum;
            log_rc.push_back({bus.rownum, bus.colnum});
        end
    end

    function automatic logic [DW-1:0] pix(input kind_e k, input int r, input int c, input int base);
        case (k)
            K_CONST:  return DW'(base);
            K_RAMP:   return DW'(c + base);
            K_RAND:   return DW'($urandom);
            K_BLOCKS: return ((r == 1 && c == 1) || (r == 0 && (c == 2 || c == 3))) ? DW'(1) : DW'(0);
            default:  return '0;
        endcase
    endfunction

    task automatic send(input int r, input int c, input logic [DW-1:0] v);
        exp_t e;
        @(negedge clock);
        bus.valid = 1'b1;
        bus.din   = v;
        img[r][c] = v;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.data = DW'((int'(img[r-1][c-1]) + int'(img[r-1][c]) + int'(img[r][c-1]) + int'(v) + 2) / 4);
            e.row  = CW'(r / 2);
            e.col  = CW'(c / 2);
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.valid = 1'b0;
            bus.din   = DW'($urandom);
        end
    endtask

    task automatic send_frame(input kind_e k, input int base, input int pair_stall, input int mid_stall);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (c % 2 == 1) idle(pair_stall);
                if (c == IW / 2 - 1) idle(mid_stall);
                send(r, c, pix(k, r, c, base));
            end
        end
    endtask

    task automatic drain(input string name, input int p0, input int want);
        idle(4);
        checks++;
        if (pulses - p0 !== want) begin
            failures++;
            $display("FAIL %s_pulse_count got=%0d want=%0d", name, pulses - p0, want);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_pulses got=%0d pending want=0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        bus.valid = 1'b0;
        bus.din   = '0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.dataout !== '0 || bus.validout !== 1'b0 || bus.rownum !== '0 || bus.colnum !== '0) begin
            failures++;
            $display("FAIL reset_outputs got data=%0d valid=%b row=%0d col=%0d want all 0",
                     bus.dataout, bus.validout, bus.rownum, bus.colnum);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_constant();
        int p0 = pulses;
        send_frame(K_CONST, 100, 0, 0);
        drain("constant", p0, NOUT);
        checks++;
        if (last_row !== CW'(OH - 1) || last_col !== CW'(OW - 1)) begin
            failures++;
            $display("FAIL constant_last_coord got row=%0d col=%0d want row=%0d col=%0d",
                     last_row, last_col, OH - 1, OW - 1);
        end
        checks++;
        if (got[OH-1][OW-1] !== 8'd100) begin
            failures++;
            $display("FAIL constant_value got=%0d want=100", got[OH-1][OW-1]);
        end
    endtask

    task automatic test_ramp();
        int p0 = pulses;
        send_frame(K_RAMP, 0, 0, 0);
        drain("ramp", p0, NOUT);
        checks++;
        if (got[0][0] !== 8'd1 || got[2][1] !== 8'd3) begin
            failures++;
            $display("FAIL ramp_values got c0=%0d c1=%0d want c0=1 c1=3", got[0][0], got[2][1]);
        end
        p0 = pulses;
        send_frame(K_RAMP, 250, 0, 0);
        drain("ramp_wrap", p0, NOUT);
        checks++;
        if (got[1][2] !== 8'd255 || got[1][3] !== 8'd1) begin
            failures++;
            $display("FAIL ramp_wrap_values got c2=%0d c3=%0d want c2=255 c3=1", got[1][2], got[1][3]);
        end
    endtask

    task automatic test_max_values();
        int p0 = pulses;
        send_frame(K_CONST, 255, 0, 0);
        drain("max", p0, NOUT);
        checks++;
        if (got[OH-1][OW-1] !== 8'd255 || got[0][0] !== 8'd255) begin
            failures++;
            $display("FAIL max_values got=%0d,%0d want=255", got[0][0], got[OH-1][OW-1]);
        end
        p0 = pulses;
        send_frame(K_BLOCKS, 0, 0, 0);
        drain("blocks", p0, NOUT);
        checks++;
        if (got[0][0] !== 8'd0 || got[0][1] !== 8'd1) begin
            failures++;
            $display("FAIL rounding_blocks got b0=%0d b1=%0d want b0=0 b1=1", got[0][0], got[0][1]);
        end
    endtask

    task automatic test_stalls();
        int p0 = pulses;
        send_frame(K_RAMP, 0, 20, 400);
        drain("stalls", p0, NOUT);
        checks++;
        if (got[0][0] !== 8'd1 || got[OH-1][1] !== 8'd3) begin
            failures++;
            $display("FAIL stalls_values got c0=%0d c1=%0d want c0=1 c1=3", got[0][0], got[OH-1][1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        int n0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < IW; c++) send(r, c, 8'd77);
        end
        for (int c = 0; c < 6; c++) send(5, c, 8'd77);
        idle(2);
        checks++;
        if (bus.dataout !== 8'd77 || bus.validout !== 1'b0) begin
            failures++;
            $display("FAIL hold_before_reset got data=%0d valid=%b want data=77 valid=0",
                     bus.dataout, bus.validout);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dataout !== '0 || bus.validout !== 1'b0 || bus.rownum !== '0 || bus.colnum !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got data=%0d valid=%b row=%0d col=%0d want all 0",
                     bus.dataout, bus.validout, bus.rownum, bus.colnum);
        end
        repeat (4) begin
            @(negedge clock);
            bus.valid = 1'b1;
            bus.din   = DW'($urandom);
        end
        @(negedge clock);
        bus.valid = 1'b0;
        reset_n   = 1'b1;
        sb_q.delete();
        p0 = pulses;
        n0 = log_rc.size();
        send_frame(K_CONST, 50, 0, 0);
        drain("after_reset", p0, NOUT);
        checks++;
        if (log_rc.size() <= n0) begin
            failures++;
            $display("FAIL after_reset_first_coord got no pulse want row=0 col=0");
        end else if (log_rc[n0] !== '0) begin
            failures++;
            $display("FAIL after_reset_first_coord got row=%0d col=%0d want row=0 col=0",
                     log_rc[n0][2*CW-1:CW], log_rc[n0][CW-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        int n0 = log_rc.size();
        send_frame(K_RAND, 0, 0, 0);
        send_frame(K_RAND, 0, 0, 0);
        drain("back_to_back", p0, 2 * NOUT);
        checks++;
        if (log_rc.size() <= n0 + NOUT) begin
            failures++;
            $display("FAIL frame2_first_coord got no pulse want row=0 col=0");
        end else if (log_rc[n0 + NOUT] !== '0) begin
            failures++;
            $display("FAIL frame2_first_coord got row=%0d col=%0d want row=0 col=0",
                     log_rc[n0 + NOUT][2*CW-1:CW], log_rc[n0 + NOUT][CW-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_max_values();
        test_stalls();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
